param_fifo: RTL and testbench

Parametrised single-clock FIFO for the Lease Cache memory-controller test environment, replacing the fixed 8x8 buffer with configurable width, depth, read mode and status thresholds. It buffers request/response words between the traffic generator and the controller under test. It adds occupancy count, almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous flush.

---
 rtl/param_fifo.sv | 151 +++++++++++++++
 tb/tb_param_fifo.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/param_fifo.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags, sticky error flags,
// synchronous flush and selectable registered or first-word-fall-through read mode.
module param_fifo #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned DEPTH         = 8,
    parameter int unsigned FWFT          = 0,
    parameter int unsigned AFULL_THRESH  = DEPTH - 2,
    parameter int unsigned AEMPTY_THRESH = 1,
    localparam int unsigned AW           = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             wr_en_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             dout_valid_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             almost_full_o,
    output logic             almost_empty_o,
    output logic [AW:0]      count_o,
    output logic             overflow_o,
    output logic             underflow_o
);

    if (WIDTH < 1) begin : g_bad_width
        $error("param_fifo: WIDTH must be at least 1");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("param_fifo: DEPTH must be a power of two and at least 2");
    end
    if (FWFT > 1) begin : g_bad_fwft
        $error("param_fifo: FWFT must be 0 or 1");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
        $error("param_fifo: AFULL_THRESH must be in 1..DEPTH");
    end
    if (AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
        $error("param_fifo: AEMPTY_THRESH must be in 0..DEPTH-1");
    end

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [AW:0]   count;
    logic          empty;
    logic          full;
    logic          rd_acc;
    logic          wr_acc;

    assign wr_addr = wr_ptr_q[AW-1:0];
    assign rd_addr = rd_ptr_q[AW-1:0];
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_addr == rd_addr) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign count   = wr_ptr_q - rd_ptr_q;

    // Flush wins over both requests; a write into a full FIFO rides on a same-cycle pop.
    assign rd_acc = rd_en_i & ~empty & ~clear_i;
    assign wr_acc = wr_en_i & (~full | rd_acc) & ~clear_i;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clear_i) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + (AW + 1)'(1);
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + (AW + 1)'(1);
            end
            overflow_d  = overflow_q | (wr_en_i & ~wr_acc);
            underflow_d = underflow_q | (rd_en_i & empty);
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left unreset; the pointers alone define validity.
    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            mem_q[wr_addr] <= din_i;
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign dout_o       = mem_q[rd_addr];
        assign dout_valid_o = ~empty;
    end else begin : g_std
        logic [WIDTH-1:0] dout_q, dout_d;
        logic             valid_q, valid_d;

        always_comb begin
            dout_d  = dout_q;
            valid_d = 1'b0;
            if (clear_i) begin
                dout_d = '0;
            end else if (rd_acc) begin
                dout_d  = mem_q[rd_addr];
                valid_d = 1'b1;
            end
        end

        always_ff @(posedge clk_i or negedge reset_ni) begin
            if (!reset_ni) begin
                dout_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                dout_q  <= dout_d;
                valid_q <= valid_d;
            end
        end

        assign dout_o       = dout_q;
        assign dout_valid_o = valid_q;
    end

    assign full_o         = full;
    assign empty_o        = empty;
    assign count_o        = count;
    assign almost_full_o  = (32'(count) >= AFULL_THRESH);
    assign almost_empty_o = (32'(count) <= AEMPTY_THRESH);
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_param_fifo.sv
// Bench for param_fifo: a registered-read and a FWFT instance share stimulus and are checked
// every cycle against a queue-based model, plus literal checks for the planned scenarios.
module tb_param_fifo;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       clear = 1'b0;
    logic       we = 1'b0;
    logic       re = 1'b0;
    logic [7:0] din = 8'h00;

    logic [7:0] d0_dout, d1_dout;
    logic       d0_valid, d1_valid, d0_full, d1_full, d0_empty, d1_empty;
    logic       d0_af, d1_af, d0_ae, d1_ae, d0_ovf, d1_ovf, d0_unf, d1_unf;
    logic [3:0] d0_count, d1_count;

    always #5 clk = ~clk;

    param_fifo #(.WIDTH(8), .DEPTH(8), .FWFT(0), .AFULL_THRESH(6), .AEMPTY_THRESH(1)) dut0 (
        .clk_i(clk), .reset_ni(reset_n), .clear_i(clear), .din_i(din), .wr_en_i(we),
        .rd_en_i(re), .dout_o(d0_dout), .dout_valid_o(d0_valid), .full_o(d0_full),
        .empty_o(d0_empty), .almost_full_o(d0_af), .almost_empty_o(d0_ae),
        .count_o(d0_count), .overflow_o(d0_ovf), .underflow_o(d0_unf)
    );

    param_fifo #(.WIDTH(8), .DEPTH(8), .FWFT(1), .AFULL_THRESH(6), .AEMPTY_THRESH(1)) dut1 (
        .clk_i(clk), .reset_ni(reset_n), .clear_i(clear), .din_i(din), .wr_en_i(we),
        .rd_en_i(re), .dout_o(d1_dout), .dout_valid_o(d1_valid), .full_o(d1_full),
        .empty_o(d1_empty), .almost_full_o(d1_af), .almost_empty_o(d1_ae),
        .count_o(d1_count), .overflow_o(d1_ovf), .underflow_o(d1_unf)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: contents as a queue, flags as plain bits.
    logic [7:0] mq[$];
    bit         m_ovf = 0;
    bit         m_unf = 0;
    bit         m_valid = 0;
    logic [7:0] m_dout = 8'h00;
    bit         run = 0;

    task automatic model_reset();
        mq.delete();
        m_ovf   = 0;
        m_unf   = 0;
        m_valid = 0;
        m_dout  = 8'h00;
    endtask

    task automatic model_edge();
        int sz;
        bit ra, wa;
        sz = mq.size();
        if (!reset_n) begin
            model_reset();
        end else if (clear) begin
            model_reset();
        end else begin
            ra = re && sz > 0;
            wa = we && (sz < 8 || ra);
            m_valid = 0;
            if (ra) begin
                m_dout  = mq.pop_front();
                m_valid = 1;
            end
            if (we && !wa) m_ovf = 1;
            if (re && sz == 0) m_unf = 1;
            if (wa) mq.push_back(din);
        end
    endtask

    task automatic step(input bit c, input bit w, input bit r, input logic [7:0] d);
        clear = c;
        we    = w;
        re    = r;
        din   = d;
        @(posedge clk);
        model_edge();
        #1;
        clear = 0;
        we    = 0;
        re    = 0;
    endtask

    always @(negedge clk) begin
        if (run) begin
            int sz;
            sz = mq.size();
            chk("count0", d0_count, sz);
            chk("count1", d1_count, sz);
            chk("empty0", d0_empty, sz == 0);
            chk("empty1", d1_empty, sz == 0);
            chk("full0", d0_full, sz == 8);
            chk("full1", d1_full, sz == 8);
            chk("afull0", d0_af, sz >= 6);
            chk("afull1", d1_af, sz >= 6);
            chk("aempty0", d0_ae, sz <= 1);
            chk("aempty1", d1_ae, sz <= 1);
            chk("ovf0", d0_ovf, m_ovf);
            chk("ovf1", d1_ovf, m_ovf);
            chk("unf0", d0_unf, m_unf);
            chk("unf1", d1_unf, m_unf);
            chk("dout0", d0_dout, m_dout);
            chk("valid0", d0_valid, m_valid);
            chk("valid1", d1_valid, sz > 0);
            if (sz > 0) chk("dout1", d1_dout, mq[0]);
        end
    end

    initial begin
        run = 1;
        // Reset values
        #12;
        chk("rst_empty", d0_empty, 1);
        chk("rst_aempty", d0_ae, 1);
        chk("rst_count", d0_count, 0);
        chk("rst_valid0", d0_valid, 0);
        chk("rst_valid1", d1_valid, 0);
        chk("rst_dout0", d0_dout, 0);
        @(posedge clk);
        #1;
        reset_n = 1;

        // Fill, overflow and drain
        for (int i = 1; i <= 8; i++) begin
            step(0, 1, 0, 8'(i));
            if (i == 5) chk("afull_at5", d0_af, 0);
            if (i == 6) chk("afull_at6", d0_af, 1);
            if (i == 7) chk("full_at7", d0_full, 0);
        end
        chk("full_at8", d0_full, 1);
        chk("model_size8", mq.size(), 8);
        step(0, 1, 0, 8'hFF);
        chk("ovf_set", d0_ovf, 1);
        chk("ovf_count8", d0_count, 8);
        for (int i = 1; i <= 8; i++) begin
            step(0, 0, 1, 8'h00);
            chk("drain_data", d0_dout, i);
            chk("drain_valid", d0_valid, 1);
        end
        step(0, 0, 1, 8'h00);
        chk("unf_set", d0_unf, 1);
        chk("unf_valid0", d0_valid, 0);
        chk("unf_dout_hold", d0_dout, 8'h08);

        // Simultaneous read and write at full
        step(1, 0, 0, 8'h00);
        for (int i = 1; i <= 8; i++) step(0, 1, 0, 8'(8'h10 + i));
        step(0, 1, 1, 8'hAA);
        chk("rw_full_ovf", d0_ovf, 0);
        chk("rw_full_count", d0_count, 8);
        chk("rw_full_dout", d0_dout, 8'h11);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, 8'h00);
            if (i == 7) chk("rw_full_last", d0_dout, 8'hAA);
        end

        // FWFT presentation and pop
        step(0, 1, 0, 8'h5A);
        chk("fwft_dout", d1_dout, 8'h5A);
        chk("fwft_valid", d1_valid, 1);
        step(0, 0, 1, 8'h00);
        chk("fwft_pop_valid", d1_valid, 0);
        chk("fwft_pop_empty", d1_empty, 1);

        // Wrap-around streaming with occupancy held in 3..5
        begin
            int occ, nw, nr, cyc;
            bit w, r;
            occ = 0; nw = 0; nr = 0; cyc = 0;
            while ((nw < 40 || nr < 40) && cyc < 400) begin
                w = nw < 40 && (occ < 3 || (occ < 5 && $urandom_range(0, 1) == 1));
                r = occ > 0 && (nw == 40 || (occ > 3 && $urandom_range(0, 1) == 1));
                step(0, w, r, nw[7:0]);
                if (w) nw++;
                if (r) begin
                    chk("wrap_data", d0_dout, nr);
                    nr++;
                end
                occ = occ + int'(w) - int'(r);
                chk("wrap_count_le5", d0_count <= 4'd5, 1);
                cyc++;
            end
            chk("wrap_done", nr, 40);
        end

        // Flush with stored words and both error flags set
        step(0, 0, 1, 8'h00);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 8'(8'h20 + i));
        step(0, 1, 0, 8'hEE);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 8'h00);
        chk("flush_pre_count", d0_count, 4);
        chk("flush_pre_ovf", d0_ovf, 1);
        chk("flush_pre_unf", d0_unf, 1);
        step(1, 1, 0, 8'h77);
        chk("flush_count", d0_count, 0);
        chk("flush_ovf", d0_ovf, 0);
        chk("flush_unf", d0_unf, 0);
        chk("flush_dout0", d0_dout, 0);
        chk("flush_valid1", d1_valid, 0);

        // Randomised traffic: write-heavy then read-heavy to reach both boundaries
        for (int i = 0; i < 300; i++) begin
            bit c, w, r;
            c = $urandom_range(0, 63) == 0;
            w = (i < 150) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            r = (i < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step(c, w, r, 8'($urandom));
        end

        // Asynchronous reset between edges
        step(1, 0, 0, 8'h00);
        step(0, 1, 0, 8'h41);
        step(0, 1, 0, 8'h42);
        step(0, 1, 1, 8'h43);
        chk("arst_pre_valid", d0_valid, 1);
        chk("arst_pre_dout", d0_dout, 8'h41);
        #2;
        reset_n = 0;
        model_reset();
        #1;
        chk("arst_count", d0_count, 0);
        chk("arst_empty", d0_empty, 1);
        chk("arst_valid0", d0_valid, 0);
        chk("arst_dout0", d0_dout, 0);
        chk("arst_valid1", d1_valid, 0);
        step(0, 1, 0, 8'h11);
        reset_n = 1;
        step(0, 1, 0, 8'h33);
        chk("post_rst_dout1", d1_dout, 8'h33);
        chk("post_rst_count", d0_count, 1);
        step(0, 0, 1, 8'h00);
        chk("post_rst_dout0", d0_dout, 8'h33);

        @(negedge clk);
        run = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
